// File: rtl/fixed_weight_cww_core.sv
// HQC fixed-weight sampler (constant-weight-word method) fed by an external SHAKE256 stream.
// Define FW_CWW_CYCLE_COUNT_EN to add the cycle_count output.
module fixed_weight_cww_core #(
  parameter parameter_set = "hqc256",
  parameter int N = (parameter_set == "hqc128") ? 17669 :
                    (parameter_set == "hqc192") ? 35851 : 57637,
  parameter int M = (parameter_set == "hqc128") ? 15 : 16,
  parameter int WEIGHT = (parameter_set == "hqc128") ? 75 :
                         (parameter_set == "hqc192") ? 114 : 149,
  parameter int LOG_WEIGHT = $clog2(WEIGHT),
  parameter int SEED_SIZE = 320,
  parameter int MAX_VECTORS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [3:0]            sk_seed_addr,
  input  logic [31:0]           sk_seed,
  input  logic                  sk_seed_wen,
  input  logic [1:0]            request_another_vector,
  output logic                  done,
  output logic                  valid_vector,
  output logic [M-1:0]          error_loc,
  input  logic                  rd_error_loc,
  input  logic [LOG_WEIGHT-1:0] rd_addr_error_loc,
  output logic                  seed_valid_internal,
  input  logic                  seed_ready_internal,
  output logic [31:0]           din_shake,
  output logic                  shake_out_capture_ready,
  input  logic [31:0]           dout_shake_scrambled,
  output logic                  force_done_shake,
  input  logic                  dout_valid_sh_internal
`ifdef FW_CWW_CYCLE_COUNT_EN
  ,
  output logic [31:0]           cycle_count
`endif
);

  localparam int SEED_WORDS = SEED_SIZE / 32;
  localparam int VCW = $clog2(MAX_VECTORS + 1);
  localparam logic [31:0] OUT_BITS = 32'(32 * WEIGHT * MAX_VECTORS);
  localparam logic [31:0] IN_BITS = 32'(SEED_SIZE);
  localparam logic [M-1:0] N_M = M'(N);
  localparam logic [LOG_WEIGHT-1:0] LAST_IDX = LOG_WEIGHT'(WEIGHT - 1);
  localparam logic [LOG_WEIGHT-1:0] PENULT_IDX = LOG_WEIGHT'(WEIGHT - 2);

  typedef enum logic [3:0] {
    IDLE, FLUSH, HDR0, HDR1, SEED, SQUEEZE, REDUCE, WRITE, DEDUP, DONE
  } state_t;

  state_t state, state_nxt;

  logic [31:0]           seed_ram [SEED_WORDS];
  logic [M-1:0]          loc_ram [WEIGHT];

  logic [3:0]            seed_cnt;
  logic [VCW-1:0]        vec_cnt;
  logic [LOG_WEIGHT-1:0] idx, jdx;
  logic [31:0]           dvd;
  logic [M-1:0]          rem, divisor, cur;
  logic [4:0]            div_cnt;
  logic                  loading;

  logic                  trigger_start, trigger_more;
  logic [M:0]            rem_shift;
  logic                  rem_ge;
  logic [M-1:0]          rem_nxt, pos, loc_rd;
  logic                  dup, last_j;
  logic                  loc_we;
  logic [M-1:0]          loc_wdata;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt               = state;
    seed_valid_internal     = 1'b0;
    din_shake               = '0;
    shake_out_capture_ready = 1'b0;
    force_done_shake        = 1'b0;
    done                    = 1'b0;
    trigger_start           = 1'b0;
    trigger_more            = 1'b0;
    loc_we                  = 1'b0;
    // One restoring-division step: only the remainder is kept.
    rem_shift = {rem, dvd[31]};
    rem_ge    = rem_shift >= {1'b0, divisor};
    rem_nxt   = rem_ge ? M'(rem_shift - {1'b0, divisor}) : rem_shift[M-1:0];
    pos       = M'(idx) + rem;
    loc_rd    = loc_ram[jdx];
    dup       = !loading && (loc_rd == cur);
    last_j    = (jdx == LAST_IDX);
    loc_wdata = pos;
    case (state)
      IDLE: begin
        if (start) begin
          trigger_start = 1'b1;
          state_nxt     = FLUSH;
        end else if (request_another_vector != 2'b00 && valid_vector) begin
          if (vec_cnt >= VCW'(MAX_VECTORS)) begin
            trigger_start = 1'b1;
            state_nxt     = FLUSH;
          end else begin
            trigger_more = 1'b1;
            state_nxt    = SQUEEZE;
          end
        end
      end
      FLUSH: begin
        force_done_shake = 1'b1;
        state_nxt        = HDR0;
      end
      HDR0: begin
        seed_valid_internal = 1'b1;
        din_shake           = OUT_BITS;
        if (seed_ready_internal) state_nxt = HDR1;
      end
      HDR1: begin
        seed_valid_internal = 1'b1;
        din_shake           = IN_BITS;
        if (seed_ready_internal) state_nxt = SEED;
      end
      SEED: begin
        seed_valid_internal = 1'b1;
        din_shake           = seed_ram[seed_cnt];
        if (seed_ready_internal && seed_cnt == 4'(SEED_WORDS - 1)) state_nxt = SQUEEZE;
      end
      SQUEEZE: begin
        shake_out_capture_ready = 1'b1;
        if (dout_valid_sh_internal) state_nxt = REDUCE;
      end
      REDUCE: begin
        if (div_cnt == 5'd31) state_nxt = WRITE;
      end
      WRITE: begin
        loc_we    = 1'b1;
        state_nxt = (idx == LAST_IDX) ? DEDUP : SQUEEZE;
      end
      DEDUP: begin
        if (dup) begin
          loc_we    = 1'b1;
          loc_wdata = M'(idx);
        end
        if (!loading && (dup || last_j) && idx == '0) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_vector <= 1'b0;
      error_loc    <= '0;
      seed_cnt     <= '0;
      vec_cnt      <= '0;
      idx          <= '0;
      jdx          <= '0;
      dvd          <= '0;
      rem          <= '0;
      divisor      <= '0;
      cur          <= '0;
      div_cnt      <= '0;
      loading      <= 1'b0;
    end else begin
      if (rd_error_loc) error_loc <= loc_ram[rd_addr_error_loc];
      case (state)
        IDLE: begin
          if (trigger_start) begin
            valid_vector <= 1'b0;
            vec_cnt      <= '0;
            seed_cnt     <= '0;
            idx          <= '0;
          end else if (trigger_more) begin
            valid_vector <= 1'b0;
            idx          <= '0;
          end
        end
        SEED: if (seed_ready_internal) seed_cnt <= seed_cnt + 4'd1;
        SQUEEZE: begin
          if (dout_valid_sh_internal) begin
            dvd     <= dout_shake_scrambled;
            rem     <= '0;
            divisor <= N_M - M'(idx);
            div_cnt <= '0;
          end
        end
        REDUCE: begin
          rem     <= rem_nxt;
          dvd     <= {dvd[30:0], 1'b0};
          div_cnt <= div_cnt + 5'd1;
        end
        WRITE: begin
          if (idx == LAST_IDX) begin
            idx     <= PENULT_IDX;
            jdx     <= PENULT_IDX;
            loading <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DEDUP: begin
          // A load cycle fetches loc[i] through the scan port before j starts at i+1.
          if (loading) begin
            cur     <= loc_rd;
            jdx     <= jdx + 1'b1;
            loading <= 1'b0;
          end else if (dup || last_j) begin
            if (idx != '0) begin
              idx     <= idx - 1'b1;
              jdx     <= idx - 1'b1;
              loading <= 1'b1;
            end
          end else begin
            jdx <= jdx + 1'b1;
          end
        end
        DONE: begin
          valid_vector <= 1'b1;
          vec_cnt      <= vec_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (sk_seed_wen && state == IDLE && sk_seed_addr < 4'(SEED_WORDS))
      seed_ram[sk_seed_addr] <= sk_seed;
  end

  always_ff @(posedge clk) begin
    if (loc_we && !rst) loc_ram[idx] <= loc_wdata;
  end

`ifdef FW_CWW_CYCLE_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)                                cycle_count <= '0;
    else if (trigger_start || trigger_more) cycle_count <= '0;
    else if (state != IDLE)                 cycle_count <= cycle_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_fixed_weight_cww_core.sv
// Directed bench for fixed_weight_cww_core (hqc128) with a behavioural SHAKE stream source.
module tb_fixed_weight_cww_core;
  localparam int N = 17669;
  localparam int M = 15;
  localparam int W = 75;
  localparam int LW = 7;

  logic          clk = 1'b0;
  logic          rst, start, sk_seed_wen, rd_error_loc;
  logic [3:0]    sk_seed_addr;
  logic [31:0]   sk_seed;
  logic [1:0]    request_another_vector;
  logic          done, valid_vector;
  logic [M-1:0]  error_loc;
  logic [LW-1:0] rd_addr_error_loc;
  logic          seed_valid_internal, seed_ready_internal;
  logic [31:0]   din_shake, dout_shake_scrambled;
  logic          shake_out_capture_ready, force_done_shake, dout_valid_sh_internal;
`ifdef FW_CWW_CYCLE_COUNT_EN
  logic [31:0]   cycle_count;
`endif

  always #5 clk = ~clk;

  fixed_weight_cww_core #(.parameter_set("hqc128")) dut (
    .clk(clk), .rst(rst), .start(start),
    .sk_seed_addr(sk_seed_addr), .sk_seed(sk_seed), .sk_seed_wen(sk_seed_wen),
    .request_another_vector(request_another_vector),
    .done(done), .valid_vector(valid_vector), .error_loc(error_loc),
    .rd_error_loc(rd_error_loc), .rd_addr_error_loc(rd_addr_error_loc),
    .seed_valid_internal(seed_valid_internal), .seed_ready_internal(seed_ready_internal),
    .din_shake(din_shake), .shake_out_capture_ready(shake_out_capture_ready),
    .dout_shake_scrambled(dout_shake_scrambled), .force_done_shake(force_done_shake),
    .dout_valid_sh_internal(dout_valid_sh_internal)
`ifdef FW_CWW_CYCLE_COUNT_EN
    , .cycle_count(cycle_count)
`endif
  );

  int vecs = 0;
  int miscompares = 0;
  int mode = 0;
  int sidx = 0;
  int force_cnt = 0;
  int done_cnt = 0;
  logic [31:0] din_q[$];
  int exp_loc[W];
  int got[W];
  int first[W];

  // Stream source: mode 0 pseudo-random, mode 1 all zero, mode 2 zero except words 3 and 7.
  function automatic logic [31:0] word_at(input int md, input int k);
    logic [31:0] kk;
    kk = 32'(k);
    case (md)
      0:       return ((kk + 32'd1) * 32'h9E3779B9) ^ (kk << 11) ^ 32'h2545F491;
      1:       return 32'd0;
      default: return (k == 3) ? 32'd497 : (k == 7) ? 32'd493 : 32'd0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (force_done_shake) begin
      force_cnt++;
      sidx = 0;
    end
    if (done) done_cnt++;
    seed_ready_internal = ($urandom_range(0, 3) != 0);
    if (seed_valid_internal && seed_ready_internal) din_q.push_back(din_shake);
    dout_valid_sh_internal = ($urandom_range(0, 2) != 0);
    dout_shake_scrambled = word_at(mode, sidx);
    if (shake_out_capture_ready && dout_valid_sh_internal) sidx++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vecs++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic build_exp(input int md, input int base);
    logic [63:0] w64;
    for (int i = 0; i < W; i++) begin
      w64 = {32'd0, word_at(md, base + i)};
      exp_loc[i] = i + int'(w64 % 64'(N - i));
    end
    for (int i = W - 2; i >= 0; i--) begin
      for (int j = i + 1; j < W; j++) begin
        if (exp_loc[i] == exp_loc[j]) begin
          exp_loc[i] = i;
          break;
        end
      end
    end
  endtask

  task automatic wait_done(input string tag, input int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 20000) begin
      step();
      n++;
    end
    step();
    step();
    check({tag, "_done_count"}, 64'(done_cnt - d0), 64'd1);
    check({tag, "_valid_vector"}, 64'(valid_vector), 64'd1);
  endtask

  task automatic run_start(input string tag);
    int d0;
    din_q.delete();
    d0 = done_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(tag, d0);
  endtask

  task automatic run_request(input string tag, input logic [1:0] req);
    int d0;
    d0 = done_cnt;
    request_another_vector = req;
    step();
    request_another_vector = 2'b00;
    wait_done(tag, d0);
  endtask

  task automatic check_locs(input string tag);
    int bad;
    rd_error_loc = 1'b1;
    for (int a = 0; a < W; a++) begin
      rd_addr_error_loc = LW'(a);
      step();
      got[a] = int'(error_loc);
    end
    rd_error_loc = 1'b0;
    for (int i = 0; i < W; i++)
      check($sformatf("%s_loc%0d", tag, i), 64'(got[i]), 64'(exp_loc[i]));
    bad = 0;
    for (int i = 0; i < W; i++) begin
      if (got[i] >= N) bad++;
      for (int j = i + 1; j < W; j++)
        if (got[i] == got[j]) bad++;
    end
    check({tag, "_distinct_in_range"}, 64'(bad), 64'd0);
  endtask

  initial begin
    int f0, same, n;
    rst = 1'b1;
    start = 1'b0;
    sk_seed_wen = 1'b0;
    sk_seed_addr = '0;
    sk_seed = '0;
    request_another_vector = 2'b00;
    rd_error_loc = 1'b0;
    rd_addr_error_loc = '0;
    seed_ready_internal = 1'b0;
    dout_valid_sh_internal = 1'b0;
    dout_shake_scrambled = '0;
    repeat (3) step();
    check("rst_done", 64'(done), 64'd0);
    check("rst_valid_vector", 64'(valid_vector), 64'd0);
    check("rst_error_loc", 64'(error_loc), 64'd0);
    check("rst_seed_valid", 64'(seed_valid_internal), 64'd0);
    check("rst_capture_ready", 64'(shake_out_capture_ready), 64'd0);
    check("rst_force_done", 64'(force_done_shake), 64'd0);
    check("rst_din_shake", 64'(din_shake), 64'd0);
    rst = 1'b0;
    step();

    for (int k = 0; k < 10; k++) begin
      sk_seed_wen = 1'b1;
      sk_seed_addr = 4'(k);
      sk_seed = 32'hC0DE0000 + 32'(k) * 32'h01010101;
      step();
    end
    sk_seed_wen = 1'b0;

    // First vector: header words, seed order, single flush pulse.
    mode = 0;
    f0 = force_cnt;
    run_start("v1");
    check("v1_flush_pulses", 64'(force_cnt - f0), 64'd1);
    check("v1_din_words", 64'(din_q.size()), 64'd12);
    if (din_q.size() == 12) begin
      check("v1_hdr_outbits", 64'(din_q[0]), 64'd9600);
      check("v1_hdr_inbits", 64'(din_q[1]), 64'd320);
      for (int k = 0; k < 10; k++)
        check($sformatf("v1_seed%0d", k), 64'(din_q[2 + k]),
              64'(32'hC0DE0000 + 32'(k) * 32'h01010101));
    end
    build_exp(0, 0);
    check_locs("v1");
    first = got;
    repeat (3) step();
    check("read_hold", 64'(error_loc), 64'(exp_loc[W - 1]));

    // Continued stream vectors, no reseed.
    repeat (10) step();
    f0 = force_cnt;
    run_request("v2", 2'b11);
    check("v2_no_flush", 64'(force_cnt - f0), 64'd0);
    build_exp(0, W);
    check_locs("v2");
    same = 0;
    for (int i = 0; i < W; i++) if (got[i] == first[i]) same++;
    check("v2_differs_v1", 64'(same == W), 64'd0);

    repeat (10) step();
    run_request("v3", 2'b01);
    build_exp(0, 2 * W);
    check_locs("v3");

    repeat (10) step();
    f0 = force_cnt;
    run_request("v4", 2'b10);
    check("v4_no_flush", 64'(force_cnt - f0), 64'd0);
    build_exp(0, 3 * W);
    check_locs("v4");

    // Session exhausted: the request reseeds, so the stream restarts.
    repeat (10) step();
    f0 = force_cnt;
    run_request("v5", 2'b11);
    check("v5_reseed_flush", 64'(force_cnt - f0), 64'd1);
    build_exp(0, 0);
    check_locs("v5");

    // Colliding positions 3 and 7 at 500.
    mode = 2;
    run_start("dup");
    build_exp(2, 0);
    check_locs("dup");
    check("dup_loc3", 64'(got[3]), 64'd3);
    check("dup_loc7", 64'(got[7]), 64'd500);

    // All-zero words give the identity vector.
    mode = 1;
    run_start("zero");
    build_exp(1, 0);
    check_locs("zero");

    // Reset mid-squeeze aborts without a done pulse.
    mode = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (sidx < 10 && n < 2000) begin
      step();
      n++;
    end
    check("abort_reached_squeeze", 64'(sidx >= 10), 64'd1);
    rst = 1'b1;
    f0 = done_cnt;
    step();
    step();
    check("abort_valid_vector", 64'(valid_vector), 64'd0);
    check("abort_capture_ready", 64'(shake_out_capture_ready), 64'd0);
    check("abort_seed_valid", 64'(seed_valid_internal), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    rst = 1'b0;
    repeat (200) step();
    check("abort_no_done", 64'(done_cnt - f0), 64'd0);
    run_start("fresh");
    build_exp(0, 0);
    check_locs("fresh");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end
endmodule
